// File: rtl/shift_exec_if.sv
// -----------------------------------------------------------------------------
// shift_exec_if
// Bundles the decode->shift handshake, the shift->MEM handshake and the
// pipeline flush for the shift execution stage.
//
// Signals:
//   in_valid      decode presents a shift op
//   in_ready      stage accepts the op this cycle
//   in_a          value to be shifted
//   in_b          register source, bits [4:0] are the shift amount
//   in_imm_shamt  immediate shift amount
//   in_use_imm    1 = immediate amount, 0 = in_b[4:0]
//   in_right      1 = right shift, 0 = left shift
//   in_arith      1 = arithmetic, 0 = logical
//   in_rd         destination register tag
//   flush         squash every in-flight op
//   out_valid     result presented to MEM
//   out_ready     MEM accepts the result
//   out_result    shifted value
//   out_rd        destination tag of out_result
//
// Modports: master = decode/MEM side, slave = the shift stage.
// -----------------------------------------------------------------------------
interface shift_exec_if #(
    parameter int RD_W = 5
);
    logic            in_valid;
    logic            in_ready;
    logic [31:0]     in_a;
    logic [31:0]     in_b;
    logic [4:0]      in_imm_shamt;
    logic            in_use_imm;
    logic            in_right;
    logic            in_arith;
    logic [RD_W-1:0] in_rd;
    logic            flush;
    logic            out_valid;
    logic            out_ready;
    logic [31:0]     out_result;
    logic [RD_W-1:0] out_rd;

    modport master (
        output in_valid,
        output in_a,
        output in_b,
        output in_imm_shamt,
        output in_use_imm,
        output in_right,
        output in_arith,
        output in_rd,
        output flush,
        output out_ready,
        input  in_ready,
        input  out_valid,
        input  out_result,
        input  out_rd
    );

    modport slave (
        input  in_valid,
        input  in_a,
        input  in_b,
        input  in_imm_shamt,
        input  in_use_imm,
        input  in_right,
        input  in_arith,
        input  in_rd,
        input  flush,
        input  out_ready,
        output in_ready,
        output out_valid,
        output out_result,
        output out_rd
    );
endinterface

// File: rtl/shift_exec_stage.sv
// -----------------------------------------------------------------------------
// shift_exec_stage
// Two-stage shift execution unit. S1 registers the operands of an accepted op,
// the shifter works on S1, and S2 registers the result and destination tag
// that are presented to the MEM stage. Each stage has its own valid bit, so a
// full pipeline sustains one op per cycle and stalls cleanly under MEM
// backpressure. A flush squashes both stages at the next clock edge.
//
// Ports:
//   clk    single clock, rising edge
//   rst_n  asynchronous active-low reset, clears valids and data
//   io     shift_exec_if.slave (in_* handshake, flush, out_* handshake)
//
// Also in this file:
//   shifter               combinational 32-bit barrel shifter (4 modes)
//   shift_exec_stage_chk  assertion checker bound to the stage internals
// -----------------------------------------------------------------------------

// -----------------------------------------------------------------------------
// shifter
// Combinational 32-bit shifter. Left shifts ignore the arithmetic flag since
// arithmetic and logical left shifts are identical.
//   a       value to shift
//   shamt   shift amount 0..31
//   right   1 = right shift
//   arith   1 = sign-filling right shift
//   result  shifted value
// -----------------------------------------------------------------------------
module shifter (
    input  logic [31:0] a,
    input  logic [4:0]  shamt,
    input  logic        right,
    input  logic        arith,
    output logic [31:0] result
);
    // Select one of the four shift flavours
    always_comb begin
        result = 32'd0;
        case ({right, arith})
            2'b00:   result = a << shamt;
            2'b01:   result = a <<< shamt;
            2'b10:   result = a >> shamt;
            2'b11:   result = $unsigned($signed(a) >>> shamt);
            default: result = 32'd0;
        endcase
    end
endmodule

// -----------------------------------------------------------------------------
// shift_exec_stage_chk
// Protocol assertions on the stage outputs.
//   clk, rst_n   clock and reset of the observed stage
//   flush        pipeline squash
//   in_ready     stage input ready
//   out_valid    stage output valid
//   out_ready    downstream ready
//   out_result   stage result
//   out_rd       stage destination tag
// -----------------------------------------------------------------------------
module shift_exec_stage_chk #(
    parameter int RD_W = 5
) (
    input logic            clk,
    input logic            rst_n,
    input logic            flush,
    input logic            in_ready,
    input logic            out_valid,
    input logic            out_ready,
    input logic [31:0]     out_result,
    input logic [RD_W-1:0] out_rd
);
    // A flushing cycle never offers acceptance
    a_no_accept_in_flush: assert property (
        @(posedge clk) disable iff (!rst_n)
        flush |-> !in_ready
    );

    // A stalled result stays on the bus unchanged
    a_stall_hold: assert property (
        @(posedge clk) disable iff (!rst_n)
        (out_valid && !out_ready && !flush) |=>
            (out_valid && $stable(out_result) && $stable(out_rd))
    );

    // Flush empties the output stage at the next edge
    a_flush_clears: assert property (
        @(posedge clk) disable iff (!rst_n)
        flush |=> !out_valid
    );
endmodule

// -----------------------------------------------------------------------------
// shift_exec_stage (top)
// -----------------------------------------------------------------------------
module shift_exec_stage #(
    parameter int RD_W = 5
) (
    input  logic        clk,
    input  logic        rst_n,
    shift_exec_if.slave io
);
    // S1: operand register
    logic            s1_valid_r;
    logic [31:0]     s1_a_r;
    logic [4:0]      s1_shamt_r;
    logic            s1_right_r;
    logic            s1_arith_r;
    logic [RD_W-1:0] s1_rd_r;

    // S2: result register
    logic            s2_valid_r;
    logic [31:0]     s2_result_r;
    logic [RD_W-1:0] s2_rd_r;

    // Handshake / control decode
    logic            s1_adv_s;
    logic            s2_drain_s;
    logic            in_ready_s;
    logic            accept_s;
    logic [4:0]      sel_shamt_s;
    logic            s1_valid_nxt_s;
    logic            s2_valid_nxt_s;
    logic [31:0]     shift_res_s;
    logic            unused_b_hi_s;

    // Only the low five bits of in_b form a shift amount
    assign unused_b_hi_s = ^io.in_b[31:5];

    // Stage-advance, input-ready and shift-amount selection
    always_comb begin
        // S1 moves into S2 whenever S2 is free or is being emptied this cycle
        s1_adv_s   = s1_valid_r && (!s2_valid_r || io.out_ready);
        // Ready tracks out_ready combinationally so a full pipe streams at 1/clk
        in_ready_s = rst_n && !io.flush && (!s1_valid_r || s1_adv_s);
        accept_s   = io.in_valid && in_ready_s;
        s2_drain_s = s2_valid_r && io.out_ready;
        if (io.in_use_imm) begin
            sel_shamt_s = io.in_imm_shamt;
        end else begin
            sel_shamt_s = io.in_b[4:0];
        end
    end

    // Next-state of both valid bits; flush wins over every other event
    always_comb begin
        s1_valid_nxt_s = s1_valid_r;
        s2_valid_nxt_s = s2_valid_r;
        if (io.flush) begin
            s1_valid_nxt_s = 1'b0;
            s2_valid_nxt_s = 1'b0;
        end else begin
            if (accept_s) begin
                s1_valid_nxt_s = 1'b1;
            end else if (s1_adv_s) begin
                s1_valid_nxt_s = 1'b0;
            end else begin
                s1_valid_nxt_s = s1_valid_r;
            end

            if (s1_adv_s) begin
                s2_valid_nxt_s = 1'b1;
            end else if (s2_drain_s) begin
                s2_valid_nxt_s = 1'b0;
            end else begin
                s2_valid_nxt_s = s2_valid_r;
            end
        end
    end

    // Single shifter, fed entirely from the operand register
    shifter u_shifter (
        .a      (s1_a_r),
        .shamt  (s1_shamt_r),
        .right  (s1_right_r),
        .arith  (s1_arith_r),
        .result (shift_res_s)
    );

    // S1 operand register: captures the op on acceptance
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_valid_r <= 1'b0;
            s1_a_r     <= 32'd0;
            s1_shamt_r <= 5'd0;
            s1_right_r <= 1'b0;
            s1_arith_r <= 1'b0;
            s1_rd_r    <= {RD_W{1'b0}};
        end else begin
            s1_valid_r <= s1_valid_nxt_s;
            if (accept_s) begin
                s1_a_r     <= io.in_a;
                s1_shamt_r <= sel_shamt_s;
                s1_right_r <= io.in_right;
                s1_arith_r <= io.in_arith;
                s1_rd_r    <= io.in_rd;
            end
        end
    end

    // S2 result register: loads the shifter output when S1 advances
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s2_valid_r  <= 1'b0;
            s2_result_r <= 32'd0;
            s2_rd_r     <= {RD_W{1'b0}};
        end else begin
            s2_valid_r <= s2_valid_nxt_s;
            // A squashed op is not worth loading; holding keeps the bus quiet
            if (s1_adv_s && !io.flush) begin
                s2_result_r <= shift_res_s;
                s2_rd_r     <= s1_rd_r;
            end
        end
    end

    assign io.in_ready   = in_ready_s;
    assign io.out_valid  = s2_valid_r;
    assign io.out_result = s2_result_r;
    assign io.out_rd     = s2_rd_r;

    shift_exec_stage_chk #(
        .RD_W (RD_W)
    ) u_chk (
        .clk        (clk),
        .rst_n      (rst_n),
        .flush      (io.flush),
        .in_ready   (in_ready_s),
        .out_valid  (s2_valid_r),
        .out_ready  (io.out_ready),
        .out_result (s2_result_r),
        .out_rd     (s2_rd_r)
    );
endmodule

// File: doc/shift_exec_stage.md
SHIFT_EXEC_STAGE -- requirements
Module: shift_exec_stage

Interface
REQ-001 Parameter: RD_W, default 5, destination-register tag width.
REQ-002 Port: clk  input  1  single clock; all state updates on rising edge.
REQ-003 Port: rst_n  input  1  asynchronous active-low reset.
REQ-004 Port: in_valid  input  1  upstream (decode) presents a shift op.
REQ-005 Port: in_ready  output  1  stage can accept the op this cycle.
REQ-006 Port: in_a  input  32  value to be shifted.
REQ-007 Port: in_b  input  32  register source; bits [4:0] give the shift amount when in_use_imm=0.
REQ-008 Port: in_imm_shamt  input  5  immediate shift amount.
REQ-009 Port: in_use_imm  input  1  1 = immediate shift amount, 0 = in_b[4:0].
REQ-010 Port: in_right  input  1  1 = right shift, 0 = left shift.
REQ-011 Port: in_arith  input  1  1 = arithmetic, 0 = logical.
REQ-012 Port: in_rd  input  RD_W  destination tag, carried with the op.
REQ-013 Port: flush  input  1  synchronous squash of all in-flight ops.
REQ-014 Port: out_valid  output  1  result available to the MEM stage.
REQ-015 Port: out_ready  input  1  MEM stage accepts the result this cycle.
REQ-016 Port: out_result  output  32  shifted result.
REQ-017 Port: out_rd  output  RD_W  destination tag of out_result.

Function
REQ-018 Two-stage pipeline: S1 is the operand register; S2 is the result register. Each stage has its own valid bit.
REQ-019 Input handshake: an op is accepted when in_valid && in_ready && !flush. On acceptance, S1 captures in_a, the selected shamt, in_right, in_arith and in_rd.
REQ-020 The existing Shifter module is instantiated once. Its inputs come from S1: (S1.a, S1.shamt, S1.right, S1.arith).
REQ-021 Advance conditions:
- S2 loads the Shifter output and S1.rd when S1 is valid and (S2 is empty or out_ready=1).
- S2 empties when out_valid && out_ready and nothing advances into it.
REQ-022 in_ready = rst_n && !flush && (S1 empty || S1 advancing this cycle). in_ready depends combinationally on out_ready.
REQ-023 Latency: 2 cycles from acceptance edge to out_valid=1 when out_ready is held at 1. Throughput: 1 op per cycle.
REQ-024 Ordering: results leave strictly in acceptance order. No op is dropped or duplicated except by flush or reset.
REQ-025 Stall: while out_valid && !out_ready, out_result and out_rd hold stable. With S1 also full, in_ready=0.
REQ-026 Flush:
- At the next edge, clears both valid bits.
- Blocks acceptance in the same cycle; flush wins over a simultaneous in_valid.
- A result handshaken in the flush cycle (out_valid && out_ready) counts as delivered.
REQ-027 Shift amount is always 0..31; in_b[31:5] are ignored. Shamt 0 passes in_a unchanged for all four modes.
REQ-028 out_valid is driven directly by the S2 valid bit.

Reset
REQ-029 rst_n low: asynchronously clears both valid bits and all data registers to 0, giving out_valid=0, out_result=0, out_rd=0 and in_ready=0.
REQ-030 First rising clk edge after rst_n deasserts: in_ready=1. Assertion of rst_n mid-operation discards all in-flight ops.

Verification
REQ-031 Reset: hold rst_n=0 for 3 cycles with in_valid=1 -> out_valid=0, in_ready=0, out_result=0; after release, in_ready=1 and no stray output.
REQ-032 Immediate SRA: in_a=0xFFFFFF38, in_imm_shamt=4, in_use_imm=1, right=1, arith=1, rd=7, out_ready=1 -> 2 cycles later out_valid=1, out_result=0xFFFFFFF3, out_rd=7, for exactly one cycle.
REQ-033 Register shamt, back-to-back ops, in_a=0x08FF76F8 and in_b=0x00000032 (shamt 18) for both:
- op 1: SLL -> 0xDBE00000;
- op 2, accepted the next cycle: SRL -> 0x0000023F;
- results appear on consecutive cycles.
REQ-034 Backpressure: out_ready=0, present 3 ops (tags 1,2,3) -> tags 1 and 2 accepted, then in_ready=0 and out_rd=1 held stable; raise out_ready -> tags 1,2,3 delivered in order with no gaps.
REQ-035 Flush: both stages full, in_valid=1, flush=1 for 1 cycle -> next cycle out_valid=0, and the presented op is not captured.
REQ-036 Sweep all 32 shamt values x 4 modes for in_a in {0xFFFFFF38, 0x08FF76F8, 0x80000000} -> out_result matches the Verilog <<, <<<, >>, >>> results on 32 bits.
